// File: rtl/tli4970_pkg.sv
// Shared definitions for the TLI4970 SPI sensor emulator.
// TLI4970_EMU_PARITY_EN selects odd parity in frame bit 14.
package tli4970_pkg;

    localparam int MSG_BIT    = 15;
    localparam int PARITY_BIT = 14;
    localparam int OCD_BIT    = 13;
    localparam int VALUE_MSB  = 12;
    localparam int FRAME_BITS = 16;

    localparam logic [7:0] ADDR_CURRENT = 8'd0;
    localparam logic [7:0] ADDR_CONTROL = 8'd1;
    localparam logic [7:0] ADDR_FRAMES  = 8'd2;
    localparam logic [7:0] ADDR_ERRORS  = 8'd3;

    localparam int CTL_SEND_STATUS = 0;
    localparam int CTL_OCD         = 1;
    localparam int CTL_ENABLE      = 2;
    localparam int CTL_FORCE_PERR  = 3;

    localparam logic [31:0] BAD_ADDR_DATA = 32'hdeadbeef;

`ifdef TLI4970_EMU_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    // Assemble one sensor word; parity makes the total ones count odd.
    function automatic logic [15:0] build_frame(
        input logic        status,
        input logic        ocd,
        input logic        force_perr,
        input logic [12:0] cur,
        input logic [7:0]  aborted_lo
    );
        logic [15:0] w;
        w = '0;
        w[MSG_BIT] = status;
        w[OCD_BIT] = ocd;
        w[VALUE_MSB:0] = status ? {aborted_lo, 5'b0} : cur;
        w[PARITY_BIT] = PARITY_EN & (~(^w) ^ force_perr);
        return w;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/tli4970_emulator_sync_edge_detect.sv
// Input synchronizer followed by registered rise/fall pulses.
// Pulses appear SYNC_STAGES+1 clocks after the pin changes.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    // Shift the pin through the synchronizer and compare with last value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            prev <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
            rise <= sync[SYNC_STAGES-1] & ~prev;
            fall <= ~sync[SYNC_STAGES-1] & prev;
        end
    end

endmodule

// File: rtl/tli4970_emulator.sv
// Avalon-programmable SPI responder emulating one TLI4970 sensor.
// Define TLI4970_EMU_PARITY_EN to enable odd parity and FORCE_PARITY_ERR.
module tli4970_emulator
    import tli4970_pkg::*;
#(
    parameter int CLOCK_SPEED_HZ = 50_000_000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        waitrequest,
    input  logic        ss_n_i,
    input  logic        sck_i,
    output logic        miso_o,
    output logic        miso_oe_o
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || CLOCK_SPEED_HZ <= 0) begin : g_bad_param
        $error("tli4970_emulator: illegal parameter value");
    end

    logic        ss_rise, ss_fall;
    logic        sck_rise, sck_fall;
    logic [12:0] cur_q;
    logic        ctl_send, ctl_ocd, ctl_en, ctl_force;
    logic [31:0] frames;
    logic [15:0] aborted, overrun;
    state_t      state;
    logic [14:0] shreg;
    logic [4:0]  bit_cnt;
    logic        ovr_seen;
    logic        rd_done;
    logic [31:0] rd_mux;
    logic [15:0] load_word;
    logic        unused;

    assign unused = &{1'b0, writedata[31:13]};

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (ss_n_i),
        .rise    (ss_rise),
        .fall    (ss_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (sck_i),
        .rise    (sck_rise),
        .fall    (sck_fall)
    );

    assign load_word = build_frame(ctl_send, ctl_ocd, ctl_force,
                                   cur_q, aborted[7:0]);

    // Register writes; one-shot bits clear at LOAD unless rewritten then.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_q     <= '0;
            ctl_send  <= 1'b0;
            ctl_ocd   <= 1'b0;
            ctl_en    <= 1'b0;
            ctl_force <= 1'b0;
        end else begin
            if (state == LOAD) begin
                ctl_send  <= 1'b0;
                ctl_force <= 1'b0;
            end
            if (write) begin
                unique case (address)
                    ADDR_CURRENT: cur_q <= writedata[12:0];
                    ADDR_CONTROL: begin
                        ctl_send  <= writedata[CTL_SEND_STATUS];
                        ctl_ocd   <= writedata[CTL_OCD];
                        ctl_en    <= writedata[CTL_ENABLE];
                        ctl_force <= PARITY_EN & writedata[CTL_FORCE_PERR];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Read data selection.
    always_comb begin
        rd_mux = BAD_ADDR_DATA;
        unique case (address)
            ADDR_CURRENT: rd_mux = {19'd0, cur_q};
            ADDR_CONTROL: rd_mux = {28'd0, ctl_force, ctl_en, ctl_ocd, ctl_send};
            ADDR_FRAMES:  rd_mux = frames;
            ADDR_ERRORS:  rd_mux = {overrun, aborted};
            default:      rd_mux = BAD_ADDR_DATA;
        endcase
    end

    // Two-cycle read: capture in the first cycle, release wait in the second.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_done  <= 1'b0;
            readdata <= '0;
        end else begin
            rd_done <= read & ~rd_done;
            if (read & ~rd_done) begin
                readdata <= rd_mux;
            end
        end
    end

    assign waitrequest = ~write & ~(read & rd_done);

    // Frame sequencer with registered MISO, output enable and counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            ovr_seen  <= 1'b0;
            miso_o    <= 1'b0;
            miso_oe_o <= 1'b0;
            frames    <= '0;
            aborted   <= '0;
            overrun   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    miso_o    <= 1'b0;
                    miso_oe_o <= 1'b0;
                    if (ss_fall) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    shreg    <= load_word[14:0];
                    bit_cnt  <= '0;
                    ovr_seen <= 1'b0;
                    if (ss_rise) begin
                        aborted   <= sat_inc(aborted);
                        miso_o    <= 1'b0;
                        miso_oe_o <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        miso_o    <= load_word[MSG_BIT];
                        miso_oe_o <= ctl_en;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        aborted   <= sat_inc(aborted);
                        miso_o    <= 1'b0;
                        miso_oe_o <= 1'b0;
                        state     <= IDLE;
                    end else if (sck_rise) begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'(FRAME_BITS - 1)) begin
                            miso_o <= 1'b0;
                            state  <= DONE;
                        end
                    end else if (sck_fall) begin
                        shreg  <= {shreg[13:0], 1'b0};
                        miso_o <= shreg[14];
                    end
                end
                DONE: begin
                    miso_o <= 1'b0;
                    if (ss_rise) begin
                        frames    <= frames + 32'd1;
                        miso_oe_o <= 1'b0;
                        state     <= IDLE;
                    end else if (sck_rise && !ovr_seen) begin
                        overrun  <= sat_inc(overrun);
                        ovr_seen <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tli4970_emulator.sv
// Directed plus randomized bench for tli4970_emulator.
// Expected frames come from an arithmetic model of the sensor word.
module tb_tli4970_emulator;

`ifdef TLI4970_EMU_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int HALF = 25;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        ss_n_i;
    logic        sck_i;
    logic        miso_o;
    logic        miso_oe_o;

    int checks = 0;
    int errors = 0;

    logic [12:0] m_cur;
    bit          m_send, m_ocd, m_en, m_force;
    int unsigned m_frames;
    int          m_abort, m_ovr;

    logic [31:0] rx, rd;
    logic        oe_seen, oe_after;
    logic [15:0] w;
    int          waits;

    tli4970_emulator dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .address     (address),
        .write       (write),
        .writedata   (writedata),
        .read        (read),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .ss_n_i      (ss_n_i),
        .sck_i       (sck_i),
        .miso_o      (miso_o),
        .miso_oe_o   (miso_oe_o)
    );

    always #10 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cur = '0; m_send = 0; m_ocd = 0; m_en = 0; m_force = 0;
        m_frames = 0; m_abort = 0; m_ovr = 0;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d);
        if (a == 8'd0) m_cur = d[12:0];
        if (a == 8'd1) begin
            m_send  = d[0];
            m_ocd   = d[1];
            m_en    = d[2];
            m_force = PAR_EN & d[3];
        end
    endtask

    function automatic logic [15:0] model_word();
        int v;
        v = m_send ? (m_abort % 256) * 32 : int'(m_cur);
        v = v + (m_send ? 32768 : 0) + (m_ocd ? 8192 : 0);
        if (PAR_EN && ((($countones(v) % 2) == 0) != m_force)) v = v + 16384;
        return 16'(v);
    endfunction

    function automatic logic [31:0] model_rx(input logic [15:0] word, input int n);
        logic [31:0] e;
        e = 0;
        for (int i = 0; i < n; i++)
            e = {e[30:0], (i < 16) ? word[15-i] : 1'b0};
        return e;
    endfunction

    task automatic model_frame(input int n);
        if (n < 16) m_abort = (m_abort < 65535) ? m_abort + 1 : m_abort;
        else begin
            m_frames++;
            if (n > 16) m_ovr = (m_ovr < 65535) ? m_ovr + 1 : m_ovr;
        end
        m_send = 0;
        m_force = 0;
    endtask

    task automatic av_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clock);
        address = a; writedata = d; write = 1'b1;
        @(negedge clock);
        write = 1'b0;
        model_write(a, d);
    endtask

    task automatic av_read(input logic [7:0] a, output logic [31:0] d,
                           output int nw);
        @(negedge clock);
        address = a; read = 1'b1;
        #1;
        nw = 0;
        while (waitrequest === 1'b1 && nw < 8) begin
            nw++;
            @(negedge clock);
            #1;
        end
        d = readdata;
        @(posedge clock);
        #1 read = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [7:0] a,
                             input logic [31:0] exp);
        logic [31:0] d;
        int nw;
        av_read(a, d, nw);
        check(tag, d, exp);
    endtask

    task automatic check_counters(input string tag);
        check_reg({tag, "_frames"}, 8'd2, m_frames);
        check_reg({tag, "_errors"}, 8'd3, (32'(m_ovr) << 16) | 32'(m_abort));
    endtask

    task automatic spi_frame(input int n, input bit lw, input logic [31:0] lw_data,
                             output logic [31:0] r, output logic oe_in,
                             output logic oe_out);
        r = 0;
        @(negedge clock);
        ss_n_i = 1'b0;
        if (lw) begin
            repeat (4) @(negedge clock);
            address = 8'd0; writedata = lw_data; write = 1'b1;
            @(negedge clock);
            write = 1'b0;
            repeat (HALF - 5) @(negedge clock);
        end else begin
            repeat (HALF) @(negedge clock);
        end
        oe_in = miso_oe_o;
        for (int i = 0; i < n; i++) begin
            r = {r[30:0], miso_o};
            sck_i = 1'b1;
            repeat (HALF) @(negedge clock);
            sck_i = 1'b0;
            repeat (HALF) @(negedge clock);
        end
        ss_n_i = 1'b1;
        repeat (4) @(posedge clock);
        #1 oe_out = miso_oe_o;
        repeat (HALF) @(negedge clock);
    endtask

    task automatic run_frame(input string tag, input int n);
        w = model_word();
        spi_frame(n, 1'b0, 32'd0, rx, oe_seen, oe_after);
        if (m_en) check({tag, "_rx"}, rx, model_rx(w, n));
        check({tag, "_oe"}, 32'(oe_seen), 32'(m_en));
        check({tag, "_oe_off"}, 32'(oe_after), 32'd0);
        model_frame(n);
    endtask

    initial begin
        reset_n = 1'b0; address = '0; write = 1'b0; writedata = '0;
        read = 1'b0; ss_n_i = 1'b1; sck_i = 1'b0;
        model_reset();
        #35;
        check("rst_miso", 32'(miso_o), 32'd0);
        check("rst_oe", 32'(miso_oe_o), 32'd0);
        check("rst_wait", 32'(waitrequest), 32'd1);
        check("rst_rdata", readdata, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(negedge clock);
        check_counters("init");
        check_reg("init_ctl", 8'd1, 32'd0);

        av_write(8'd0, 32'hFFFF_EABC);
        check_reg("cur_mask", 8'd0, 32'h0000_0ABC);
        av_write(8'd1, 32'h4);
        run_frame("basic", 16);
        check_counters("basic");

        run_frame("abort3", 3);
        run_frame("abort5", 5);
        av_write(8'd1, 32'h7);
        check("status_word", 32'(model_word()), PAR_EN ? 32'h0000_A040 : 32'h0000_A040);
        run_frame("status", 16);
        check_reg("send_clr", 8'd1, 32'h6);
        run_frame("after_status", 16);
        check_counters("status");

        run_frame("abort7", 7);
        check_counters("abort7");

        run_frame("overrun", 20);
        check_counters("overrun");

        repeat (5) begin
            @(negedge clock); sck_i = 1'b1;
            repeat (6) @(negedge clock); sck_i = 1'b0;
            repeat (6) @(negedge clock);
        end
        check_counters("idle_sck");

        @(negedge clock); ss_n_i = 1'b0;
        @(negedge clock); ss_n_i = 1'b1;
        repeat (12) @(negedge clock);
        model_frame(0);
        check_counters("zero_bit");

        av_write(8'd0, 32'h0123);
        w = model_word();
        spi_frame(16, 1'b1, 32'h1FFF, rx, oe_seen, oe_after);
        check("tear_old_rx", rx, model_rx(w, 16));
        model_frame(16);
        model_write(8'd0, 32'h1FFF);
        check_reg("tear_reg", 8'd0, 32'h1FFF);
        run_frame("tear_new", 16);

        av_write(8'd9, 32'h1234_5678);
        av_read(8'd9, rd, waits);
        check("bad_addr_data", rd, 32'hdeadbeef);
        check("bad_addr_waits", 32'(waits), 32'd1);
        check("wait_idle", 32'(waitrequest), 32'd1);

        for (int k = 0; k < 12; k++) begin
            int n;
            av_write(8'd0, $urandom);
            av_write(8'd1, {28'd0, 4'($urandom)} | (k < 10 ? 32'h4 : 32'h0));
            n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(7, 20)) : 16;
            run_frame($sformatf("rnd%0d", k), n);
            check_reg($sformatf("rnd%0d_ctl", k), 8'd1,
                      {28'd0, m_force, m_en, m_ocd, m_send});
        end
        check_counters("rnd");

        @(negedge clock); ss_n_i = 1'b0;
        av_write(8'd1, 32'h4);
        repeat (HALF) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            sck_i = 1'b1; repeat (HALF) @(negedge clock);
            sck_i = 1'b0; repeat (HALF) @(negedge clock);
        end
        check("mid_oe", 32'(miso_oe_o), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        check("arst_oe", 32'(miso_oe_o), 32'd0);
        check("arst_miso", 32'(miso_o), 32'd0);
        @(negedge clock);
        ss_n_i = 1'b1;
        reset_n = 1'b1;
        model_reset();
        repeat (5) @(negedge clock);
        check_counters("post_rst");
        check_reg("post_rst_cur", 8'd0, 32'd0);
        av_write(8'd0, 32'h0555);
        av_write(8'd1, 32'h6);
        run_frame("post_rst", 16);
        check_counters("post_rst_frame");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
